// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter sweep controller.
// State encoding, command mode encodings and default datapath widths.
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DWELL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_UP      = 2'd0;
  localparam logic [1:0] MODE_DOWN    = 2'd1;
  localparam logic [1:0] MODE_PP      = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DWELL_W = 4;

endpackage

// File: rtl/ctrl_dwell_timer.sv
// Loadable down-counter; expired_o is high once the count reaches zero.
// Load wins over decrement; the count saturates at zero.
module ctrl_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweeps an external up/down/hold/load counter between start and limit, dwelling at each end.
// One command at a time (cmd_ready only in IDLE); abort and cnt_value act combinationally on hold.
module counter_sweep_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [WIDTH-1:0]   cmd_start,
  input  logic [WIDTH-1:0]   cmd_limit,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic [DWELL_W-1:0] cmd_reps,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cnt_value,
  output logic               cnt_load,
  output logic [WIDTH-1:0]   cnt_load_val,
  output logic               cnt_up_down,
  output logic               cnt_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [DWELL_W-1:0] LEG_ONE = DWELL_W'(1);

  state_t               state_q;
  logic [1:0]           mode_q;
  logic [WIDTH-1:0]     start_q;
  logic [WIDTH-1:0]     limit_q;
  logic [WIDTH-1:0]     tgt_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   legs_q;
  logic                 leg_dir_q;
  logic                 last_dir_q;
  logic                 err_q;
  logic                 at_tgt;
  logic                 cmd_bad;
  logic                 kill;
  logic                 dwell_exp;

  assign at_tgt  = (cnt_value == tgt_q);
  assign kill    = abort && (state_q != ST_IDLE);
  assign cmd_bad = (cmd_mode == MODE_ILLEGAL) ||
                   ((cmd_mode == MODE_UP)   && (cmd_limit < cmd_start)) ||
                   ((cmd_mode == MODE_DOWN) && (cmd_limit > cmd_start));

  ctrl_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load_i     ((state_q == ST_RUN) && at_tgt && !abort),
    .load_val_i (dwell_q),
    .en_i       (state_q == ST_DWELL),
    .expired_o  (dwell_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_UP;
      start_q    <= '0;
      limit_q    <= '0;
      tgt_q      <= '0;
      dwell_q    <= '0;
      legs_q     <= '0;
      leg_dir_q  <= 1'b1;
      last_dir_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == ST_RUN) last_dir_q <= leg_dir_q;
      if (kill) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_valid) begin
              if (cmd_bad) begin
                err_q <= 1'b1;
              end else begin
                state_q   <= ST_LOAD;
                mode_q    <= cmd_mode;
                start_q   <= cmd_start;
                limit_q   <= cmd_limit;
                tgt_q     <= cmd_limit;
                dwell_q   <= cmd_dwell;
                legs_q    <= (cmd_reps == '0) ? LEG_ONE : cmd_reps;
                leg_dir_q <= (cmd_mode == MODE_UP) ||
                             ((cmd_mode == MODE_PP) && (cmd_limit >= cmd_start));
              end
            end
          end
          ST_LOAD: state_q <= ST_RUN;
          ST_RUN:  if (at_tgt) state_q <= ST_DWELL;
          ST_DWELL: begin
            if (dwell_exp) begin
              if (legs_q > LEG_ONE) begin
                legs_q <= legs_q - LEG_ONE;
                // Ping-pong turns around in place; the other modes reload from start.
                if (mode_q == MODE_PP) begin
                  state_q   <= ST_RUN;
                  tgt_q     <= (tgt_q == limit_q) ? start_q : limit_q;
                  leg_dir_q <= ~leg_dir_q;
                end else begin
                  state_q <= ST_LOAD;
                end
              end else begin
                state_q <= ST_DONE;
              end
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE) && !abort;
  assign err          = err_q;
  assign cnt_load     = (state_q == ST_LOAD) && !abort;
  assign cnt_load_val = start_q;
  assign cnt_hold     = (state_q == ST_RUN) ? (at_tgt || abort) : 1'b1;
  assign cnt_up_down  = (state_q == ST_RUN) ? leg_dir_q : last_dir_q;

endmodule
